// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with valid/ready handshake, registered flags and a chained carry.
// Optional saturating add/sub (SADD/SSUB) is built only when ALU_SAT_EN is defined.
module pipelined_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             err
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_ADC  = 4'b0110,
        OP_SBB  = 4'b0111,
        OP_SHL  = 4'b1000,
        OP_SHR  = 4'b1001,
        OP_PASS = 4'b1010,
        OP_CMP  = 4'b1011,
        OP_SADD = 4'b1100,
        OP_SSUB = 4'b1101
    } op_t;

    logic             advance;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_sel;
    logic             c_reg;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   adc_w;
    logic [WIDTH:0]   sbb_w;
    logic [WIDTH-1:0] flag_w;
    logic [WIDTH-1:0] nx_result;
    logic             nx_carry;
    logic             nx_zero;
    logic             nx_negative;
    logic             nx_overflow;
    logic             nx_err;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ADC/SBB take c_reg here, which already holds the carry of the op just ahead.
    always_comb begin
        add_w       = {1'b0, s1_a} + {1'b0, s1_b};
        sub_w       = {1'b0, s1_a} - {1'b0, s1_b};
        adc_w       = add_w + {{WIDTH{1'b0}}, c_reg};
        sbb_w       = sub_w - {{WIDTH{1'b0}}, c_reg};
        nx_result   = '0;
        nx_carry    = 1'b0;
        nx_overflow = 1'b0;
        nx_err      = 1'b0;
        case (s1_sel)
            OP_ADD: begin
                nx_result   = add_w[MSB:0];
                nx_carry    = add_w[WIDTH];
                nx_overflow = (s1_a[MSB] == s1_b[MSB]) && (add_w[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                nx_result   = sub_w[MSB:0];
                nx_carry    = sub_w[WIDTH];
                nx_overflow = (s1_a[MSB] != s1_b[MSB]) && (sub_w[MSB] != s1_a[MSB]);
            end
            OP_AND:  nx_result = s1_a & s1_b;
            OP_OR:   nx_result = s1_a | s1_b;
            OP_XOR:  nx_result = s1_a ^ s1_b;
            OP_NOT:  nx_result = ~s1_a;
            OP_ADC: begin
                nx_result   = adc_w[MSB:0];
                nx_carry    = adc_w[WIDTH];
                nx_overflow = (s1_a[MSB] == s1_b[MSB]) && (adc_w[MSB] != s1_a[MSB]);
            end
            OP_SBB: begin
                nx_result   = sbb_w[MSB:0];
                nx_carry    = sbb_w[WIDTH];
                nx_overflow = (s1_a[MSB] != s1_b[MSB]) && (sbb_w[MSB] != s1_a[MSB]);
            end
            OP_SHL: begin
                nx_result = {s1_a[MSB-1:0], 1'b0};
                nx_carry  = s1_a[MSB];
            end
            OP_SHR: begin
                nx_result = {1'b0, s1_a[MSB:1]};
                nx_carry  = s1_a[0];
            end
            OP_PASS: nx_result = s1_b;
            OP_CMP: begin
                nx_result   = s1_a;
                nx_carry    = sub_w[WIDTH];
                nx_overflow = (s1_a[MSB] != s1_b[MSB]) && (sub_w[MSB] != s1_a[MSB]);
            end
`ifdef ALU_SAT_EN
            OP_SADD: begin
                nx_result = add_w[WIDTH] ? {WIDTH{1'b1}} : add_w[MSB:0];
                nx_carry  = add_w[WIDTH];
            end
            OP_SSUB: begin
                nx_result = sub_w[WIDTH] ? {WIDTH{1'b0}} : sub_w[MSB:0];
                nx_carry  = sub_w[WIDTH];
            end
`endif
            default: nx_err = 1'b1;
        endcase
        // CMP reports the flags of A-B while passing A through as the result.
        flag_w      = (s1_sel == OP_CMP) ? sub_w[MSB:0] : nx_result;
        nx_zero     = (flag_w == '0);
        nx_negative = flag_w[MSB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= '0;
            out_valid <= 1'b0;
            c_reg     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            if (in_valid) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_sel <= sel;
            end
            out_valid <= s1_valid;
            // Bubbles leave the stored carry and the last flags untouched.
            if (s1_valid) begin
                result    <= nx_result;
                carry_out <= nx_carry;
                zero      <= nx_zero;
                negative  <= nx_negative;
                overflow  <= nx_overflow;
                err       <= nx_err;
                c_reg     <= nx_carry;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: a scoreboard queue fed by an arithmetic reference model,
// directed scenarios with literal expectations, then randomized traffic with stalls and resets.
module tb_pipelined_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out, zero, negative, overflow, err;

    pipelined_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .zero(zero), .negative(negative),
        .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit co, z, n, ov, er;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc;
    } ent_t;

    ent_t q[$];
    exp_t popped[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_low = -1;
    bit   model_c = 1'b0;
    bit   held_v = 1'b0;
    bit   post_rst = 1'b0;
    bit   started = 1'b0;
    exp_t held;

    function automatic exp_t mk(int res, bit co, bit z, bit n, bit ov, bit er);
        exp_t e;
        e.res = res; e.co = co; e.z = z; e.n = n; e.ov = ov; e.er = er;
        return e;
    endfunction

    // Reference: plain integer arithmetic, signed overflow by range check.
    function automatic exp_t model(int a, int b, int s, bit cin);
        exp_t e;
        int full, half, sa, sb, r, sr;
        bit arith, ill, cmp;
        full = 1 << W;
        half = 1 << (W - 1);
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        e = mk(0, 0, 0, 0, 0, 0);
        arith = 0; ill = 0; cmp = 0; r = 0; sr = 0;
        case (s)
            0:  begin r = a + b; sr = sa + sb; arith = 1; end
            1:  begin r = a - b; sr = sa - sb; arith = 1; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = (full - 1) - a;
            6:  begin r = a + b + int'(cin); sr = sa + sb + int'(cin); arith = 1; end
            7:  begin r = a - b - int'(cin); sr = sa - sb - int'(cin); arith = 1; end
            8:  begin r = (a * 2) % full; e.co = (a >= half); end
            9:  begin r = a / 2; e.co = (a % 2) == 1; end
            10: r = b;
            11: begin r = a - b; sr = sa - sb; arith = 1; cmp = 1; end
            12: begin
`ifdef ALU_SAT_EN
                r = a + b;
                if (r >= full) begin r = full - 1; e.co = 1; end
`else
                ill = 1;
`endif
            end
            13: begin
`ifdef ALU_SAT_EN
                r = a - b;
                if (r < 0) begin r = 0; e.co = 1; end
`else
                ill = 1;
`endif
            end
            default: ill = 1;
        endcase
        if (arith) begin
            e.co = (r < 0) || (r >= full);
            e.ov = (sr < -half) || (sr >= half);
            r = (r + 2 * full) % full;
        end
        if (ill) begin
            e = mk(0, 0, 1, 0, 0, 1);
        end else begin
            e.z = (r == 0);
            e.n = (r >= half);
            e.res = cmp ? a : r;
        end
        return e;
    endfunction

    function automatic bit same(exp_t x, exp_t y);
        return x.res == y.res && x.co == y.co && x.z == y.z && x.n == y.n &&
               x.ov == y.ov && x.er == y.er;
    endfunction

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic chk_e(string name, exp_t act, exp_t req);
        n_cmp++;
        if (!same(act, req)) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got res=%0h c=%0b z=%0b n=%0b v=%0b e=%0b, expected res=%0h c=%0b z=%0b n=%0b v=%0b e=%0b",
                     name, cyc, act.res, act.co, act.z, act.n, act.ov, act.er,
                     req.res, req.co, req.z, req.n, req.ov, req.er);
        end
    endtask

    task automatic lit(int idx, exp_t req, string name);
        if (idx >= popped.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: result %0d missing, got %0d results", name, idx, popped.size());
        end else begin
            chk_e(name, popped[idx], req);
        end
    endtask

    // One clock: drive after negedge, sample just after, then the posedge applies it.
    task automatic cycle(input bit r, input bit iv, input int a, input int b, input int s,
                         input bit ordy, output bit accepted);
        exp_t act;
        ent_t ent;
        bit   early;
        @(negedge clk);
        rst = r; in_valid = iv; A = W'(a); B = W'(b); sel = 4'(s); out_ready = ordy;
        #1;
        accepted = 1'b0;
        act = mk(int'(result), carry_out, zero, negative, overflow, err);
        if (started) chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
        if (!r) begin
            if (post_rst) begin
                chk("rst_out_valid", int'(out_valid), 0);
                post_rst = 1'b0;
            end
            if (held_v) begin
                chk("hold_valid", int'(out_valid), 1);
                chk_e("hold_data", act, held);
            end
            early = (q.size() == 0) || (cyc < q[0].acc + 2);
            if (early) chk("no_early_valid", int'(out_valid), 0);
            else if (q[0].acc + 2 == cyc && last_low < q[0].acc)
                chk("latency", int'(out_valid), 1);
            if (out_valid && out_ready && q.size() > 0) begin
                chk_e("result", act, q[0].e);
                void'(q.pop_front());
                popped.push_back(act);
            end
            held_v = out_valid && !out_ready;
            held = act;
            if (q.size() > 0 && cyc - q[0].acc > 40) begin
                chk("timeout", cyc - q[0].acc, 0);
                void'(q.pop_front());
            end
            if (!ordy) last_low = cyc;
            if (iv && in_ready) begin
                ent.e = model(a, b, s, model_c);
                ent.acc = cyc;
                model_c = ent.e.co;
                q.push_back(ent);
                accepted = 1'b1;
            end
        end else begin
            q.delete();
            model_c = 1'b0;
            held_v = 1'b0;
            post_rst = 1'b1;
            started = 1'b1;
        end
        cyc++;
    endtask

    task automatic op(int a, int b, int s);
        bit acc;
        cycle(0, 1, a, b, s, 1, acc);
        if (!acc) chk("accept", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 0, 0, 0, 1, acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        bit acc;
        cycle(1, 0, 0, 0, 0, 1, acc);
    endtask

    function automatic int pick();
        int edge_v[5] = '{0, 1, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 4)];
        return int'($urandom_range(0, (1 << W) - 1));
    endfunction

    initial begin
        bit acc;
        int k;

        chk_e("model_add", model(8'hF0, 8'h20, 0, 0), mk(8'h10, 1, 0, 0, 0, 0));
        chk_e("model_sub", model(8'h50, 8'h70, 1, 0), mk(8'hE0, 1, 0, 1, 0, 0));
        chk_e("model_ovf", model(8'h7F, 8'h01, 0, 0), mk(8'h80, 0, 0, 1, 1, 0));
        chk_e("model_sbb", model(8'h00, 8'h00, 7, 1), mk(8'hFF, 1, 0, 1, 0, 0));

        do_reset();
        do_reset();

        popped.delete();
        op(8'hF0, 8'h20, 0);
        drain();
        lit(0, mk(8'h10, 1, 0, 0, 0, 0), "add_f0_20");

        popped.delete();
        op(8'hFF, 8'h01, 0);
        op(8'h12, 8'h34, 6);
        drain();
        lit(0, mk(8'h00, 1, 1, 0, 0, 0), "chain_lo");
        lit(1, mk(8'h47, 0, 0, 0, 0, 0), "chain_hi");

        popped.delete();
        op(8'h50, 8'h70, 1);
        op(8'h7F, 8'h01, 0);
        drain();
        lit(0, mk(8'hE0, 1, 0, 1, 0, 0), "sub_borrow");
        lit(1, mk(8'h80, 0, 0, 1, 1, 0), "add_overflow");

        popped.delete();
        k = 0;
        for (int it = 0; it < 30 && (k < 4 || q.size() > 0); it++) begin
            cycle(0, k < 4, k + 1, k + 1, 0, !(it >= 2 && it < 5), acc);
            if (acc) k++;
        end
        chk("bp_count", popped.size(), 4);
        for (int i = 0; i < 4; i++) lit(i, mk(2 * (i + 1), 0, 0, 0, 0, 0), "bp_order");

        popped.delete();
        op(8'hFF, 8'h01, 0);
        op(8'h05, 8'h03, 14);
        op(8'h10, 8'h20, 6);
        op(8'hF0, 8'h20, 12);
        drain();
        lit(1, mk(0, 0, 1, 0, 0, 1), "illegal_1110");
        lit(2, mk(8'h30, 0, 0, 0, 0, 0), "adc_after_illegal");
`ifdef ALU_SAT_EN
        lit(3, mk(8'hFF, 1, 0, 1, 0, 0), "sadd_clamp");
`else
        lit(3, mk(0, 0, 1, 0, 0, 1), "sadd_illegal");
`endif

        popped.delete();
        op(8'hFF, 8'h01, 0);
        op(8'h80, 8'h80, 0);
        do_reset();
        op(8'h01, 8'h01, 6);
        drain();
        chk("rst_flush_count", popped.size(), 1);
        lit(0, mk(8'h02, 0, 0, 0, 0, 0), "adc_after_reset");

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, pick(), pick(),
                  int'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
